fp16_normalizer: RTL and testbench

Downstream stage of `fp_posit_mac`: converts the MAC's two's-complement fixed-point accumulator (`fixed_point_out`) and its alignment exponent (`exp_out`) into an IEEE-754 binary16 value for write-back to activation memory. Normalization is bit-serial, one left shift per cycle, to match the bit-serial datapath of the MAC. Rounding is round-to-nearest-even; out-of-range results saturate to infinity or flush to zero.

---
 rtl/fp16_normalizer.sv | 162 ++++++++++++++++
 tb/tb_fp16_normalizer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_normalizer.sv
// fp16_normalizer: converts a signed fixed-point accumulator and its biased
// alignment exponent into an IEEE-754 binary16 value. Normalization shifts
// one bit per cycle; rounding is round-to-nearest-even; out-of-range results
// saturate to infinity or flush to a signed zero (no subnormals).
//
// Handshake: an input transfers on a rising edge where in_valid && in_ready.
// in_ready is high only while the block is idle with nothing pending. The
// upstream holds in_valid and its data until the transfer happens. out_valid
// is a one-cycle pulse; fp16_out and the flags hold their value between pulses.
module fp16_normalizer #(
  parameter int ACC_WIDTH = 32,
  parameter int FRAC_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACC_WIDTH-1:0] fixed_point_in,
  input  logic [4:0]           exp_in,
  output logic [15:0]          fp16_out,
  output logic                 out_valid,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int LZW = $clog2(ACC_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 sign_q, sign_d;
  logic [ACC_WIDTH-1:0] mag_q, mag_d;
  logic [4:0]           exp_q, exp_d;
  logic [LZW-1:0]       lz_q, lz_d;
  logic                 zero_pend_q, zero_pend_d;
  logic [15:0]          fp16_q, fp16_d;
  logic                 out_valid_q, out_valid_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;

  // Rounding datapath, evaluated on the normalized magnitude
  logic [9:0]           man;
  logic                 g_bit;
  logic                 s_bit;
  logic                 round_up;
  logic [10:0]          man_rnd;
  logic signed [15:0]   e_pre;
  logic signed [15:0]   e_rnd;
  logic [9:0]           man_fin;
  logic [ACC_WIDTH-1:0] abs_in;

  assign in_ready  = (state_q == IDLE) && !zero_pend_q;
  assign fp16_out  = fp16_q;
  assign out_valid = out_valid_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  // Exponent, mantissa extraction and round-to-nearest-even
  always_comb begin
    abs_in   = fixed_point_in[ACC_WIDTH-1] ? (~fixed_point_in + 1'b1) : fixed_point_in;
    man      = mag_q[ACC_WIDTH-2 -: 10];
    g_bit    = mag_q[ACC_WIDTH-12];
    s_bit    = |mag_q[ACC_WIDTH-13:0];
    round_up = g_bit && (s_bit || man[0]);
    man_rnd  = {1'b0, man} + {10'b0, round_up};
    e_pre    = $signed(16'(ACC_WIDTH - 1 - FRAC_BITS))
             - $signed({{(16-LZW){1'b0}}, lz_q})
             + $signed({11'b0, exp_q});
    e_rnd    = man_rnd[10] ? (e_pre + 16'sd1) : e_pre;
    man_fin  = man_rnd[10] ? 10'd0 : man_rnd[9:0];
  end

  // Next-state and output logic for IDLE -> NORM -> ROUND
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    exp_d       = exp_q;
    lz_d        = lz_q;
    zero_pend_d = 1'b0;
    fp16_d      = fp16_q;
    out_valid_d = 1'b0;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    case (state_q)
      IDLE: begin
        if (zero_pend_q) begin
          // Zero input: result is +0 one edge after the accept
          out_valid_d = 1'b1;
          fp16_d      = 16'h0000;
          ovf_d       = 1'b0;
          unf_d       = 1'b0;
        end else if (in_valid) begin
          sign_d = fixed_point_in[ACC_WIDTH-1];
          mag_d  = abs_in;
          exp_d  = exp_in;
          lz_d   = '0;
          if (fixed_point_in == '0) zero_pend_d = 1'b1;
          else                      state_d     = NORM;
        end
      end
      NORM: begin
        if (mag_q[ACC_WIDTH-1]) begin
          state_d = ROUND;
        end else begin
          mag_d = mag_q << 1;
          lz_d  = lz_q + 1'b1;
        end
      end
      ROUND: begin
        out_valid_d = 1'b1;
        state_d     = IDLE;
        if (e_rnd >= 16'sd31) begin
          fp16_d = {sign_q, 15'h7C00};
          ovf_d  = 1'b1;
          unf_d  = 1'b0;
        end else if (e_rnd <= 16'sd0) begin
          fp16_d = {sign_q, 15'h0000};
          ovf_d  = 1'b0;
          unf_d  = 1'b1;
        end else begin
          fp16_d = {sign_q, e_rnd[4:0], man_fin};
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      exp_q       <= '0;
      lz_q        <= '0;
      zero_pend_q <= 1'b0;
      fp16_q      <= 16'h0000;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      lz_q        <= lz_d;
      zero_pend_q <= zero_pend_d;
      fp16_q      <= fp16_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

endmodule

// File: tb/tb_fp16_normalizer.sv
// Bench for fp16_normalizer: directed vectors plus a short back-to-back run.
// Expected {overflow, underflow, fp16} and expected output cycle are queued
// when an input is accepted; a monitor pops and compares on each out_valid.
module tb_fp16_normalizer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fixed_point_in;
  logic [4:0]  exp_in;
  logic [15:0] fp16_out;
  logic        out_valid;
  logic        overflow;
  logic        underflow;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ready_viol = 0;
  logic [17:0] exp_q[$];
  int          lat_q[$];

  fp16_normalizer #(.ACC_WIDTH(32), .FRAC_BITS(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fixed_point_in(fixed_point_in), .exp_in(exp_in), .fp16_out(fp16_out),
    .out_valid(out_valid), .overflow(overflow), .underflow(underflow)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: returns {ovf, unf, fp16}; lat = cycles from accept edge
  function automatic logic [17:0] model(input logic [31:0] acc, input logic [4:0] e,
                                        output int lat);
    longint a, mag, one, rem, half, mf;
    int p, ee;
    logic sgn;
    logic [4:0] e5;
    logic [9:0] m10;
    one = 1;
    a   = longint'($signed(acc));
    sgn = acc[31];
    mag = (a < 0) ? -a : a;
    if (mag == 0) begin
      lat = 1;
      return 18'h0;
    end
    p = 0;
    for (int i = 0; i < 32; i++) if (((mag >> i) & 1) == 1) p = i;
    lat = (31 - p) + 2;
    ee  = p + int'(e) - 10;
    if (p >= 10) mf = mag >> (p - 10);
    else         mf = mag << (10 - p);
    if (p >= 11) begin
      rem  = mag & ((one << (p - 10)) - 1);
      half = one << (p - 11);
      if (rem > half || (rem == half && (mf & 1) == 1)) mf = mf + 1;
    end
    if (mf >= 2048) begin
      mf = mf >> 1;
      ee = ee + 1;
    end
    if (ee >= 31) return {2'b10, sgn, 15'h7C00};
    if (ee <= 0)  return {2'b01, sgn, 15'h0000};
    e5  = ee[4:0];
    m10 = mf[9:0];
    return {2'b00, sgn, e5, m10};
  endfunction

  // Driver: wait for in_ready, present data, record expectation after accept
  task automatic send(input logic [31:0] acc, input logic [4:0] e, input bit keep);
    int n = 0;
    int lat;
    logic [17:0] ev;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%0b required=1", in_ready);
      return;
    end
    fixed_point_in = acc;
    exp_in         = e;
    in_valid       = 1'b1;
    @(posedge clk);
    #1;
    ev = model(acc, e, lat);
    exp_q.push_back(ev);
    lat_q.push_back(cyc + lat);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending=%0d required=0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=0x%0h required=0x%0h", name, got, want);
    end
  endtask

  // Scoreboard monitor: compare every out_valid against the queue head
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out_valid: out_valid=1 required=0 fp16=0x%0h", fp16_out);
        end else begin
          logic [17:0] ev;
          int ecyc;
          ev   = exp_q.pop_front();
          ecyc = lat_q.pop_front();
          chk("result", {14'b0, overflow, underflow, fp16_out}, {14'b0, ev});
          chk("latency_cycle", cyc, ecyc);
        end
      end else if (exp_q.size() > 0 && in_ready) begin
        ready_viol++;
      end
    end
  end

  // Test sequence
  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    fixed_point_in = '0;
    exp_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_fp16", {16'b0, fp16_out}, 32'h0);
    chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'h1);
    chk("reset_flags", {30'b0, overflow, underflow}, 32'h0);
    rst = 1'b1;

    // Basic conversions (expected values hand-derived)
    send(32'h0000_0400, 5'd15, 0); drain();   // 1.0  -> 0x3C00, lz=21
    chk("hand_3c00", 32'h3C00, {16'b0, model_val(32'h0000_0400, 5'd15)});
    send(32'hFFFF_FC00, 5'd15, 0); drain();   // -1.0 -> 0xBC00
    send(32'h8000_0000, 5'd0, 0);  drain();   // -2^31 * 2^-25 = -64 -> 0xD400
    // Rounding
    send(32'h0000_0801, 5'd15, 0); drain();   // tie, even      -> 0x4000
    send(32'h0000_0803, 5'd15, 0); drain();   // tie, odd up    -> 0x4002
    send(32'h0000_0FFF, 5'd15, 0); drain();   // carry to 4.0   -> 0x4400
    // Range limits and zero
    send(32'h7FFF_FFFF, 5'd15, 0); drain();   // overflow -> 0x7C00
    send(32'h0000_0000, 5'd9, 0);  drain();   // zero, latency 1
    // in_valid during NORM is ignored
    send(32'h0000_0400, 5'd15, 0);
    repeat (3) @(negedge clk);
    fixed_point_in = 32'h7FFF_FFFF;
    exp_in = 5'd31;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    drain();
    send(32'h0000_0001, 5'd0, 0);  drain();   // underflow -> 0x0000

    // Reset in the middle of NORM
    send(32'h0000_0001, 5'd15, 0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    chk("midreset_fp16", {16'b0, fp16_out}, 32'h0);
    chk("midreset_out_valid", {31'b0, out_valid}, 32'h0);
    chk("midreset_in_ready", {31'b0, in_ready}, 32'h1);
    chk("midreset_flags", {30'b0, overflow, underflow}, 32'h0);
    rst = 1'b1;
    repeat (40) @(negedge clk);

    // Back-to-back with in_valid held
    for (int i = 0; i < 8; i++) begin
      logic [31:0] r;
      r = $urandom >> $urandom_range(0, 28);
      if ($urandom_range(0, 1) == 1) r = ~r + 1;
      send(r, 5'($urandom_range(0, 31)), (i != 7));
    end
    drain();

    chk("ready_during_busy", ready_viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Sanity of the reference model against a hand-computed value
  function automatic logic [15:0] model_val(input logic [31:0] acc, input logic [4:0] e);
    int l;
    logic [17:0] v;
    v = model(acc, e, l);
    return v[15:0];
  endfunction

  // Watchdog
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
